// File: rtl/jtag_master.sv
// JTAG master: runs one TAP reset, IR shift, DR shift or idle-clock command at a time on TCK/TMS/TDI/TDO.
// Latency: 2*CLK_DIV clk cycles per TCK period; rsp_valid pulses one cycle after the last high phase ends.
// Backpressure: cmd_ready is low from the cycle after acceptance until the rsp_valid cycle; cmd_valid is ignored meanwhile.
//
// Ports:
//   clk, rst                       system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake; cmd_type (00 reset, 01 IR, 10 DR, 11 idle),
//                                  cmd_len (shift length / idle count, saturated to 1..32), cmd_data (TDI, LSB first)
//   rsp_valid/rsp_data             completion pulse and captured TDO bits (LSB first, upper bits zero)
//   jtag_pin_TCK/TMS/TDI/TDO       JTAG pins; TCK comes straight from a flop
// Build option: define JTAG_TDO_SYNC_EN to pass TDO through a two-flop synchronizer and sample it
// on the TCK falling edge instead of the rising edge (use CLK_DIV >= 3 in that build).
module jtag_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        jtag_pin_TCK,
    output logic        jtag_pin_TMS,
    output logic        jtag_pin_TDI,
    input  logic        jtag_pin_TDO
);

    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_IR    = 2'b01;
    localparam logic [1:0] CMD_DR    = 2'b10;
    localparam logic [1:0] CMD_IDLE  = 2'b11;

    localparam int            PW      = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);      // last low-phase cycle
    localparam logic [PW-1:0] PH_FALL = PW'(2 * CLK_DIV - 1);  // last high-phase cycle

    function automatic logic [5:0] eff_len(input logic [5:0] l);
        logic [5:0] r;
        if (l == 6'd0)       r = 6'd1;
        else if (l > 6'd32)  r = 6'd32;
        else                 r = l;
        return r;
    endfunction

    // Number of TCK periods each stage takes for a given command.
    function automatic logic [5:0] stage_len(input state_t s, input logic [1:0] t, input logic [5:0] len);
        logic [5:0] r;
        r = 6'd0;
        case (s)
            PRE: begin
                case (t)
                    CMD_RESET: r = 6'd6;
                    CMD_IR:    r = 6'd4;
                    CMD_DR:    r = 6'd3;
                    default:   r = 6'd0;
                endcase
            end
            SHIFT:   r = (t == CMD_RESET) ? 6'd0 : len;
            POST:    r = (t == CMD_IR || t == CMD_DR) ? 6'd2 : 6'd0;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Stages with zero periods are skipped: reset is PRE only, idle clocks are SHIFT only.
    function automatic state_t next_stage(input state_t s, input logic [1:0] t, input logic [5:0] len);
        state_t n;
        if (s == IDLE && stage_len(PRE, t, len) != 6'd0)
            n = PRE;
        else if ((s == IDLE || s == PRE) && stage_len(SHIFT, t, len) != 6'd0)
            n = SHIFT;
        else if (s != POST && stage_len(POST, t, len) != 6'd0)
            n = POST;
        else
            n = DONE;
        return n;
    endfunction

    function automatic logic bit_tms(input state_t s, input logic [1:0] t, input logic [5:0] len,
                                     input logic [5:0] idx);
        logic r;
        r = 1'b0;
        case (s)
            PRE: begin
                case (t)
                    CMD_RESET: r = (idx != 6'd5);
                    CMD_IR:    r = (idx < 6'd2);
                    CMD_DR:    r = (idx == 6'd0);
                    default:   r = 1'b0;
                endcase
            end
            SHIFT:   r = (t == CMD_IR || t == CMD_DR) && (idx == len - 6'd1);
            POST:    r = (idx == 6'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic bit_tdi(input state_t s, input logic [1:0] t, input logic [31:0] d,
                                     input logic [5:0] idx);
        return (s == SHIFT && (t == CMD_IR || t == CMD_DR)) ? d[idx[4:0]] : 1'b0;
    endfunction

    state_t        state, state_n;
    logic [5:0]    idx, idx_n;
    logic [PW-1:0] phase;
    logic          tck_q, tms_q, tdi_q;
    logic [1:0]    type_q;
    logic [5:0]    len_q;
    logic [31:0]   data_q;
    logic          accept, active, period_end, load_bit, capture_en, tdo_sample;
    logic [1:0]    sel_type;
    logic [5:0]    sel_len;
    logic [31:0]   sel_data;

    assign cmd_ready    = (state == IDLE) || (state == DONE);
    assign rsp_valid    = (state == DONE);
    assign accept       = cmd_valid && cmd_ready;
    assign active       = (state == PRE) || (state == SHIFT) || (state == POST);
    assign period_end   = active && (phase == PH_FALL);
    assign capture_en   = (state == SHIFT) && (type_q == CMD_IR || type_q == CMD_DR);

    // The first bit of a new command is computed from the incoming fields, later bits from the registered ones.
    assign sel_type = accept ? cmd_type : type_q;
    assign sel_len  = accept ? eff_len(cmd_len) : len_q;
    assign sel_data = accept ? cmd_data : data_q;

    assign jtag_pin_TCK = tck_q;
    assign jtag_pin_TMS = tms_q;
    assign jtag_pin_TDI = tdi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 6'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        load_bit = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (accept) begin
                    state_n  = next_stage(IDLE, sel_type, sel_len);
                    idx_n    = 6'd0;
                    load_bit = 1'b1;
                end
            end
            PRE, SHIFT, POST: begin
                if (period_end) begin
                    if (idx == stage_len(state, type_q, len_q) - 6'd1) begin
                        state_n  = next_stage(state, type_q, len_q);
                        idx_n    = 6'd0;
                        load_bit = (state_n != DONE);
                    end else begin
                        idx_n    = idx + 6'd1;
                        load_bit = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef JTAG_TDO_SYNC_EN
    logic tdo_s1, tdo_s2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdo_s1 <= 1'b0;
            tdo_s2 <= 1'b0;
        end else begin
            tdo_s1 <= jtag_pin_TDO;
            tdo_s2 <= tdo_s1;
        end
    end
    // Synchronizer delay is absorbed by waiting until the falling TCK edge.
    assign tdo_sample = capture_en && (phase == PH_FALL);
    wire   tdo_bit    = tdo_s2;
`else
    assign tdo_sample = capture_en && (phase == PH_RISE);
    wire   tdo_bit    = jtag_pin_TDO;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            type_q   <= 2'b00;
            len_q    <= 6'd1;
            data_q   <= 32'd0;
            rsp_data <= 32'd0;
        end else begin
            if (accept) begin
                type_q   <= cmd_type;
                len_q    <= eff_len(cmd_len);
                data_q   <= cmd_data;
                rsp_data <= 32'd0;
            end

            if (load_bit || period_end)
                phase <= '0;
            else if (active)
                phase <= phase + 1'b1;

            if (active && phase == PH_RISE)
                tck_q <= 1'b1;
            else if (period_end)
                tck_q <= 1'b0;

            // TMS/TDI change only at the start of a low phase; they hold through DONE and IDLE.
            if (load_bit) begin
                tms_q <= bit_tms(state_n, sel_type, sel_len, idx_n);
                tdi_q <= bit_tdi(state_n, sel_type, sel_data, idx_n);
            end

            if (tdo_sample)
                rsp_data[idx[4:0]] <= tdo_bit;
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
module tb_jtag_master;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'b00;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, tdo;
    logic        tdo_inv = 1'b0;

    int checks = 0;
    int errors = 0;

    // Target model: TDO is TDI looped back, optionally inverted.
    assign tdo = tdi ^ tdo_inv;

    always #5 clk = ~clk;

    jtag_master #(.CLK_DIV(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_len      (cmd_len),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .jtag_pin_TCK (tck),
        .jtag_pin_TMS (tms),
        .jtag_pin_TDI (tdi),
        .jtag_pin_TDO (tdo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pin sequences (one entry per TCK period) and response for one command.
    task automatic model(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d, input logic inv,
                         output int n, output logic [63:0] etms, output logic [63:0] etdi,
                         output logic [31:0] ersp);
        bit q_tms[$];
        bit q_tdi[$];
        int len;
        len  = (l == 0) ? 1 : ((l > 32) ? 32 : int'(l));
        ersp = 32'd0;
        case (t)
            2'b00: begin
                q_tms = '{1, 1, 1, 1, 1, 0};
                q_tdi = '{0, 0, 0, 0, 0, 0};
            end
            2'b11: begin
                for (int i = 0; i < len; i++) begin
                    q_tms.push_back(0);
                    q_tdi.push_back(0);
                end
            end
            default: begin
                if (t == 2'b01) q_tms = '{1, 1, 0, 0};
                else            q_tms = '{1, 0, 0};
                for (int i = 0; i < q_tms.size(); i++) q_tdi.push_back(0);
                for (int i = 0; i < len; i++) begin
                    q_tms.push_back(i == len - 1);
                    q_tdi.push_back(d[i]);
                    ersp[i] = d[i] ^ inv;
                end
                q_tms.push_back(1); q_tdi.push_back(0);
                q_tms.push_back(0); q_tdi.push_back(0);
            end
        endcase
        n    = q_tms.size();
        etms = 64'd0;
        etdi = 64'd0;
        for (int i = 0; i < n; i++) begin
            etms[i] = q_tms[i];
            etdi[i] = q_tdi[i];
        end
    endtask

    // Issue one command at a negedge and monitor it to completion. With hold set, cmd_valid
    // stays high throughout and the task returns on the rsp_valid cycle so the next command
    // is presented back-to-back.
    task automatic run_cmd(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                           input logic inv, input bit hold);
        int n, nt, first_rise, c_done;
        logic [63:0] etms, etdi, stms, stdi;
        logic [31:0] ersp;
        logic prev_tck;
        model(t, l, d, inv, n, etms, etdi, ersp);
        nt = 0; first_rise = -1; c_done = -1; prev_tck = 1'b0;
        stms = 64'd0; stdi = 64'd0;
        tdo_inv   = inv;
        cmd_type  = t;
        cmd_len   = l;
        cmd_data  = d;
        cmd_valid = 1'b1;
        chk("ready_before", 64'(cmd_ready), 64'd1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (!hold) cmd_valid = 1'b0;
                chk("ready_busy", 64'(cmd_ready), 64'd0);
            end
            if (tck && !prev_tck) begin
                if (first_rise < 0) first_rise = c;
                if (nt < 64) begin
                    stms[nt] = tms;
                    stdi[nt] = tdi;
                end
                nt++;
            end
            prev_tck = tck;
            if (rsp_valid) begin
                c_done = c;
                break;
            end
        end
        chk("rsp_seen",   64'(c_done >= 0), 64'd1);
        chk("tck_count",  64'(nt), 64'(n));
        chk("tms_seq",    stms, etms);
        chk("tdi_seq",    stdi, etdi);
        chk("first_rise", 64'(first_rise), 64'(D));
        chk("done_cycle", 64'(c_done), 64'(2 * D * n));
        chk("rsp_data",   64'(rsp_data), 64'(ersp));
        chk("ready_done", 64'(cmd_ready), 64'd1);
        if (!hold) begin
            @(negedge clk);
            chk("rsp_pulse", 64'(rsp_valid), 64'd0);
            chk("rsp_hold",  64'(rsp_data), 64'(ersp));
            chk("tck_idle",  64'(tck), 64'd0);
        end
    endtask

    task automatic rst_mid_shift();
        int seen;
        cmd_type  = 2'b10;
        cmd_len   = 6'd16;
        cmd_data  = 32'h0000FFFF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        // Period 7 of the command is SHIFT bit 4: TMS 0, TDI 1; sample index 30 is in its high phase.
        repeat (30) @(negedge clk);
        chk("pre_abort_tck", 64'(tck), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_tck",   64'(tck), 64'd0);
        chk("abort_tms",   64'(tms), 64'd1);
        chk("abort_tdi",   64'(tdi), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        chk("abort_rsp",   64'(rsp_valid), 64'd0);
        chk("abort_data",  64'(rsp_data), 64'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rst = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);
    endtask

    initial begin
        logic [1:0]  rt;
        logic [5:0]  rl;
        logic [31:0] rd;
        logic        ri;
        bit          rh;

        repeat (3) @(negedge clk);
        chk("rst_tck",   64'(tck), 64'd0);
        chk("rst_tms",   64'(tms), 64'd1);
        chk("rst_tdi",   64'(tdi), 64'd0);
        chk("rst_rsp",   64'(rsp_valid), 64'd0);
        chk("rst_data",  64'(rsp_data), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(2'b00, 6'd0,  32'h0,        1'b0, 1'b0);
        run_cmd(2'b10, 6'd8,  32'h000000A5, 1'b0, 1'b0);
        run_cmd(2'b01, 6'd5,  32'h00000001, 1'b0, 1'b0);
        run_cmd(2'b10, 6'd0,  32'hFFFFFFFF, 1'b0, 1'b0);
        run_cmd(2'b10, 6'd40, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_cmd(2'b11, 6'd7,  32'hDEADBEEF, 1'b0, 1'b0);
        run_cmd(2'b10, 6'd12, 32'h000005A3, 1'b0, 1'b1);
        run_cmd(2'b01, 6'd3,  32'h00000005, 1'b0, 1'b0);
        run_cmd(2'b10, 6'd32, 32'h12345678, 1'b1, 1'b0);

        rst_mid_shift();
        run_cmd(2'b00, 6'd0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rt = 2'($urandom_range(0, 3));
            rl = 6'($urandom_range(0, 63));
            rd = $urandom;
            ri = 1'($urandom_range(0, 1));
            rh = (i != 39) && ($urandom_range(0, 2) == 0);
            run_cmd(rt, rl, rd, ri, rh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset, with parameters and ports as listed in REQ-002 to REQ-017.
REQ-002 Parameter CLK_DIV, default 2, sets the clk cycles per TCK phase; one TCK period is 2*CLK_DIV clk cycles; minimum 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_type  input  2  command: 00 TAP reset, 01 IR shift, 10 DR shift, 11 idle clocks.
REQ-008 cmd_len  input  6  shift length or idle-clock count.
REQ-009 cmd_data  input  32  TDI data, LSB shifted first.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_data  output  32  captured TDO bits, LSB first.
REQ-012 jtag_pin_TCK  output  1  JTAG test clock.
REQ-013 jtag_pin_TMS  output  1  JTAG mode select.
REQ-014 jtag_pin_TDI  output  1  JTAG data to target.
REQ-015 jtag_pin_TDO  input  1  JTAG data from target.
REQ-016 The TAP SHALL be in Run-Test/Idle between commands once a reset command (type 00) has run.
REQ-017 jtag_pin_TCK SHALL be driven from a register, never from a combinational path or a gated clock.

Function
REQ-018 A command SHALL be accepted on the cycle where cmd_valid and cmd_ready are both high; cmd_type, cmd_len and cmd_data SHALL be registered on that cycle.
REQ-019 cmd_ready SHALL go low on the cycle after acceptance and return high on the cycle rsp_valid pulses; cmd_valid while cmd_ready is low SHALL be ignored.
REQ-020 Effective length SHALL saturate: cmd_len 0 is treated as 1, and values above 32 are treated as 32.
REQ-021 The FSM SHALL use states IDLE, PRE, SHIFT, POST and DONE, sequenced as follows:
- IDLE to PRE on acceptance.
- PRE to SHIFT after the path bits.
- SHIFT to POST after len bits.
- POST to DONE after the exit bits.
- DONE to IDLE after one cycle.
REQ-022 Each TCK period SHALL be a low phase then a high phase of CLK_DIV clk cycles each. TMS and TDI SHALL update at the start of the low phase.
REQ-023 TMS sequences per command SHALL be:
- Reset: 1,1,1,1,1,0 (6 TCK periods).
- DR: PRE 1,0,0; SHIFT len bits of 0 except the last bit 1; POST 1,0.
- IR: PRE 1,1,0,0; SHIFT as DR; POST 1,0.
- Idle: len periods with TMS 0.
REQ-024 During SHIFT, TDI bit i SHALL equal cmd_data[i]. Outside SHIFT, TDI SHALL be 0.
REQ-025 TDO for bit i SHALL be sampled into rsp_data[i] on the clk edge where the TCK register goes 0 to 1. rsp_data bits at index len and above SHALL be 0.
REQ-026 For reset and idle commands, rsp_data SHALL be 0.
REQ-027 rsp_valid SHALL pulse for exactly one cycle in DONE, one clk cycle after the final TCK high phase ends. rsp_data SHALL hold its value until the next acceptance.
REQ-028 In IDLE, TCK SHALL stay 0 and TMS/TDI SHALL hold their last values.

Reset
REQ-029 While rst is high, outputs SHALL be: jtag_pin_TCK 0, jtag_pin_TMS 1, jtag_pin_TDI 0, rsp_valid 0, rsp_data 0, cmd_ready 1, FSM in IDLE.
REQ-030 rst asserted mid-command SHALL abort the command immediately with no rsp_valid. The TAP state is then undefined until the next reset command.

Configuration
REQ-031 Macro JTAG_TDO_SYNC_EN controls TDO capture:
- Defined: jtag_pin_TDO SHALL pass through a two-flop synchronizer (reset 0), and samples SHALL be taken on the clk edge where TCK goes 1 to 0; CLK_DIV SHALL be at least 3.
- Undefined: jtag_pin_TDO SHALL be sampled directly per REQ-025.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, with CLK_DIV=2 and TDO looped back to TDI unless noted:
- Reset command -> TMS sequence 1,1,1,1,1,0 over 6 TCK periods (24 clk cycles); rsp_valid one cycle later; rsp_data=0.
- DR shift, len=8, data=0xA5 -> 13 TCKs; TDI 1,0,1,0,0,1,0,1; TMS 1,0,0,0,0,0,0,0,0,0,1,1,0; rsp_data=0x000000A5.
- IR shift, len=5, data=0x01 -> TMS 1,1,0,0,0,0,0,0,1,1,0 (11 TCKs); rsp_data=0x00000001.
- DR shift with len=0, then len=40 and data 0xFFFFFFFF -> 1 bit shifted (rsp_data=0x1), then 32 bits shifted (rsp_data=0xFFFFFFFF).
- cmd_valid held high during a DR shift -> second command accepted only on the cycle rsp_valid pulses; no TCK gap beyond 1 clk.
- rst pulse in the middle of SHIFT -> TCK=0, TMS=1, TDI=0 and cmd_ready=1 asynchronously; no rsp_valid; the next reset command completes normally.
